inst_mem_resp: RTL and testbench

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_resp.sv | 134 +++++++++++++
 tb/tb_inst_mem_resp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_resp.sv
// Instruction memory with program-load port and power-up clear.
// After reset the controller walks every word writing zero (INIT), then
// serves registered fetches and accepts load writes (RUN). Fetches that
// arrive during INIT are rejected and counted in a saturating counter.
module inst_mem_resp #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              init_busy,
  output logic [7:0]        drop_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic [ADDR_W-1:0] clr_ptr_s;
  logic [DATA_W-1:0] inst_r;
  logic [DATA_W-1:0] inst_s;
  logic              inst_valid_r;
  logic              inst_valid_s;
  logic [7:0]        drop_cnt_r;
  logic [7:0]        drop_cnt_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // Next-state, memory write port and fetch result selection.
  always_comb begin
    state_s      = state_r;
    clr_ptr_s    = clr_ptr_r;
    inst_s       = {DATA_W{1'b0}};
    inst_valid_s = 1'b0;
    drop_cnt_s   = drop_cnt_r;
    mem_we_s     = 1'b0;
    mem_waddr_s  = {ADDR_W{1'b0}};
    mem_wdata_s  = {DATA_W{1'b0}};
    mem_rdata_s  = mem[addr];
    case (state_r)
      ST_INIT: begin
        // Clear one word per cycle; the last word's write also leaves INIT.
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_ptr_r;
        mem_wdata_s = {DATA_W{1'b0}};
        clr_ptr_s   = clr_ptr_r + ADDR_W'(1);
        if (clr_ptr_r == LAST_ADDR) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
        // Fetches are refused while clearing; count them without wrapping.
        if (ce && (drop_cnt_r != 8'hFF)) begin
          drop_cnt_s = drop_cnt_r + 8'd1;
        end else begin
          drop_cnt_s = drop_cnt_r;
        end
      end
      ST_RUN: begin
        state_s     = ST_RUN;
        mem_we_s    = ld_valid;
        mem_waddr_s = ld_addr;
        mem_wdata_s = ld_data;
        if (ce) begin
          inst_valid_s = 1'b1;
          // Same-edge load to the fetched word forwards the new data.
          if (ld_valid && (ld_addr == addr)) begin
            inst_s = ld_data;
          end else begin
            inst_s = mem_rdata_s;
          end
        end else begin
          inst_s       = {DATA_W{1'b0}};
          inst_valid_s = 1'b0;
        end
      end
      default: begin
        state_s   = ST_INIT;
        clr_ptr_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Controller and fetch-result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_INIT;
      clr_ptr_r    <= {ADDR_W{1'b0}};
      inst_r       <= {DATA_W{1'b0}};
      inst_valid_r <= 1'b0;
      drop_cnt_r   <= 8'd0;
    end else begin
      state_r      <= state_s;
      clr_ptr_r    <= clr_ptr_s;
      inst_r       <= inst_s;
      inst_valid_r <= inst_valid_s;
      drop_cnt_r   <= drop_cnt_s;
    end
  end

  // Single write port; held reset suppresses clearing writes.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign inst       = inst_r;
  assign inst_valid = inst_valid_r;
  assign drop_cnt   = drop_cnt_r;
  assign init_busy  = (state_r == ST_INIT);
  assign ld_ready   = (state_r == ST_RUN);

endmodule

// File: tb/tb_inst_mem_resp.sv
// Self-checking bench for inst_mem_resp: scoreboard of expected fetch
// results plus INIT timing, reject counting and reset-clear scenarios.
module tb_inst_mem_resp;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] inst;
  logic          inst_valid;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          init_busy;
  logic [7:0]    drop_cnt;

  // Second instance with a deep memory for the saturation scenario.
  logic          rst9 = 1'b1;
  logic          ce9 = 1'b0;
  logic [8:0]    addr9 = '0;
  logic [DW-1:0] inst9;
  logic          inst_valid9;
  logic [8:0]    ld_addr9 = '0;
  logic [DW-1:0] ld_data9 = '0;
  logic          ld_ready9;
  logic          init_busy9;
  logic [7:0]    drop_cnt9;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW:0]   exp_q [$];

  always #5 clk = ~clk;

  inst_mem_resp #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .inst_valid(inst_valid), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready), .init_busy(init_busy),
    .drop_cnt(drop_cnt)
  );

  inst_mem_resp #(.ADDR_W(9), .DATA_W(DW)) dut9 (
    .clk(clk), .rst(rst9), .ce(ce9), .addr(addr9), .inst(inst9),
    .inst_valid(inst_valid9), .ld_valid(1'b0), .ld_addr(ld_addr9),
    .ld_data(ld_data9), .ld_ready(ld_ready9), .init_busy(init_busy9),
    .drop_cnt(drop_cnt9)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // Count cycles until init_busy drops (bounded), optionally poking loads.
  task automatic wait_init(input logic poke, output int cycles);
    cycles = 0;
    while (init_busy === 1'b1 && cycles < 1000) begin
      ld_valid = poke;
      ld_addr  = 6'd7;
      ld_data  = 32'hFFFF_FFFF;
      cycles++;
      step();
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1; ce = 1'b1; ld_valid = 1'b1; ld_addr = 6'd3; ld_data = 32'h1234;
    step(); step();
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    n_checks++; if (init_busy !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got busy=%b ready=%b want 1/0", init_busy, ld_ready); end
    ce = 1'b0; ld_valid = 1'b0; rst = 1'b0;
    wait_init(1'b0, cyc);
    clear_model();
    n_checks++; if (cyc != 64) begin n_fail++; $display("FAIL init_len got %0d want 64", cyc); end
    n_checks++; if (ld_ready !== 1'b1 || init_busy !== 1'b0) begin
      n_fail++; $display("FAIL run_ready got ready=%b busy=%b want 1/0", ld_ready, init_busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL init_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_load_fetch();
    logic [DW:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(i); ld_data = 32'h11 * (i + 1);
      model_mem[i] = ld_data;
      step();
    end
    ld_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        ce = 1'b1; addr = AW'(i);
        exp_q.push_back({1'b1, model_mem[i]});
      end else begin
        ce = 1'b0;
        exp_q.push_back({1'b0, 32'h0});
      end
      step();
      got = {inst_valid, inst};
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL fetch_%0d got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_write_first();
    logic [DW:0] got, exp;
    // same address: write-first
    ld_valid = 1'b1; ld_addr = 6'd5; ld_data = 32'hDEAD_BEEF; ce = 1'b1; addr = 6'd5;
    model_mem[5] = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    step();
    got = {inst_valid, inst}; exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL wr_first got %h want %h", got, exp); end
    // different addresses at one edge, then read back the loaded word
    ld_addr = 6'd9; ld_data = 32'h9999_0099; addr = 6'd1;
    exp_q.push_back({1'b1, model_mem[1]});
    model_mem[9] = 32'h9999_0099;
    step();
    got = {inst_valid, inst}; exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL indep_fetch got %h want %h", got, exp); end
    ld_valid = 1'b0; addr = 6'd9;
    exp_q.push_back({1'b1, model_mem[9]});
    step();
    got = {inst_valid, inst}; exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL indep_load got %h want %h", got, exp); end
    ce = 1'b0;
  endtask

  task automatic test_ce_pattern();
    logic [DW:0] got, exp;
    logic [2:0] pat;
    pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      ce = pat[2-i]; addr = 6'd2;
      exp_q.push_back(pat[2-i] ? {1'b1, model_mem[2]} : {1'b0, 32'h0});
      step();
      got = {inst_valid, inst}; exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ce_pat_%0d got %h want %h", i, got, exp); end
    end
    ce = 1'b0;
  endtask

  task automatic test_rst_clears();
    logic [DW:0] got, exp;
    int cyc;
    ld_valid = 1'b1; ld_addr = 6'd7; ld_data = 32'hA5; model_mem[7] = 32'hA5;
    step();
    ld_valid = 1'b0; ce = 1'b1; addr = 6'd7;
    exp_q.push_back({1'b1, model_mem[7]});
    step();
    got = {inst_valid, inst}; exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL pre_rst got %h want %h", got, exp); end
    ce = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    wait_init(1'b1, cyc);
    clear_model();
    n_checks++; if (cyc != 64) begin n_fail++; $display("FAIL reinit_len got %0d want 64", cyc); end
    for (int i = 0; i < 2; i++) begin
      ce = 1'b1; addr = (i == 0) ? 6'd7 : 6'd2;
      exp_q.push_back({1'b1, model_mem[addr]});
      step();
      got = {inst_valid, inst}; exp = exp_q.pop_front();
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL post_rst_%0d got %h want %h", i, got, exp); end
    end
    ce = 1'b0;
  endtask

  task automatic test_drop();
    int cyc;
    int bad;
    rst = 1'b1; ce = 1'b1; addr = 6'd3;
    step();
    rst = 1'b0; cyc = 0; bad = 0;
    while (init_busy === 1'b1 && cyc < 1000) begin
      if (inst_valid !== 1'b0) bad++;
      cyc++;
      step();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drop_valid got %0d valid cycles want 0", bad); end
    n_checks++; if (cyc != 64) begin n_fail++; $display("FAIL drop_init_len got %0d want 64", cyc); end
    n_checks++; if (drop_cnt !== 8'd64) begin n_fail++; $display("FAIL drop_cnt got %0d want 64", drop_cnt); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL drop_last got %b want 0", inst_valid); end
    ce = 1'b0;
    clear_model();
  endtask

  task automatic test_saturate();
    rst9 = 1'b1; ce9 = 1'b1;
    step();
    rst9 = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) begin
        n_checks++; if (drop_cnt9 !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d want 254", drop_cnt9); end
      end
    end
    n_checks++; if (drop_cnt9 !== 8'd255) begin n_fail++; $display("FAIL sat_300 got %0d want 255", drop_cnt9); end
    n_checks++; if (init_busy9 !== 1'b1 || inst_valid9 !== 1'b0) begin
      n_fail++; $display("FAIL sat_state got busy=%b valid=%b want 1/0", init_busy9, inst_valid9); end
    ce9 = 1'b0;
  endtask

  initial begin
    clear_model();
    test_reset();
    test_load_fetch();
    test_write_first();
    test_ce_pattern();
    test_rst_clears();
    test_drop();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
